// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states and default widths.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_TWOS  = 4'h6;
    localparam logic [3:0] OP_NOP   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hE;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPERAND,
        ISSUE,
        STORE_WAIT,
        WRITE,
        HALTED
    } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Bus master in front of the 16x8 memory: fetches instructions, reads operands,
// hands them to execute over valid/ready and writes store data back.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_W-ADDR_W-1:0] ex_opcode,
    output logic [ADDR_W-1:0]        ex_addr,
    output logic [DATA_W-1:0]        ex_operand,
    input  logic                     st_valid,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    output logic [ADDR_W-1:0]        pc,
    output logic                     halted
);

    localparam int OP_W = DATA_W - ADDR_W;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   wdata_reg;
    logic [OP_W-1:0]     opcode;
    logic [ADDR_W-1:0]   ir_addr;

    assign opcode     = ir[DATA_W-1:ADDR_W];
    assign ir_addr    = ir[ADDR_W-1:0];
    assign ex_opcode  = opcode;
    assign ex_addr    = ir_addr;
    assign ex_operand = operand;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        ex_valid    = 1'b0;
        st_ready    = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = pc;
                state_nxt   = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_HALT:  state_nxt = HALTED;
                    OP_NOP:   state_nxt = FETCH;
                    OP_JMP:   state_nxt = FETCH;
                    OP_STORE: state_nxt = ISSUE;
                    default:  state_nxt = OPERAND;
                endcase
            end
            OPERAND: begin
                mem_read    = 1'b1;
                mem_address = ir_addr;
                state_nxt   = ISSUE;
            end
            ISSUE: begin
                ex_valid = 1'b1;
                if (ex_ready) state_nxt = (opcode == OP_STORE) ? STORE_WAIT : FETCH;
            end
            STORE_WAIT: begin
                st_ready = 1'b1;
                if (st_valid) state_nxt = WRITE;
            end
            WRITE: begin
                mem_write   = 1'b1;
                mem_address = ir_addr;
                mem_wdata   = wdata_reg;
                state_nxt   = FETCH;
            end
            HALTED: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
        // The reset state is FETCH, yet the bus must stay quiet while reset is held.
        if (rst) mem_read = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            operand   <= '0;
            wdata_reg <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir <= mem_rdata;
                    pc <= pc + 1'b1;
                end
                DECODE: begin
                    if (opcode == OP_JMP)   pc      <= ir_addr;
                    if (opcode == OP_STORE) operand <= '0;
                end
                OPERAND:    operand <= mem_rdata;
                STORE_WAIT: if (st_valid) wdata_reg <= st_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural 16x8 memory.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mem_address;
    logic       mem_read, mem_write;
    logic [7:0] mem_wdata, mem_rdata;
    logic       ex_valid, ex_ready;
    logic [3:0] ex_opcode, ex_addr;
    logic [7:0] ex_operand;
    logic       st_valid, st_ready;
    logic [7:0] st_data;
    logic [3:0] pc;
    logic       halted;

    logic [7:0] mem [16];
    logic       tb_we;
    logic [3:0] tb_addr;
    logic [7:0] tb_data;

    typedef struct {
        logic [3:0] op;
        logic [3:0] ad;
        logic [7:0] opd;
    } ex_t;
    typedef struct {
        logic [3:0] ad;
        logic [7:0] dat;
    } wr_t;

    ex_t ex_q[$];
    wr_t wr_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  accepts  = 0;
    int  writes   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_addr(ex_addr), .ex_operand(ex_operand),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
        .pc(pc), .halted(halted)
    );

    assign mem_rdata = mem_read ? mem[mem_address] : 8'h00;

    always @(posedge clk) begin
        if (mem_write)  mem[mem_address] <= mem_wdata;
        else if (tb_we) mem[tb_addr]     <= tb_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes and writes are compared at the falling edge before they commit.
    always @(negedge clk) begin : monitor
        ex_t e;
        wr_t w;
        if (!rst && ex_valid && ex_ready) begin
            accepts++;
            check("ex_queue_nonempty", ex_q.size() != 0, 1);
            if (ex_q.size() != 0) begin
                e = ex_q.pop_front();
                check("ex_opcode", ex_opcode, e.op);
                check("ex_addr", ex_addr, e.ad);
                check("ex_operand", ex_operand, e.opd);
            end
        end
        if (!rst && mem_write) begin
            writes++;
            check("rw_exclusive", mem_read, 0);
            check("wr_queue_nonempty", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_addr", mem_address, w.ad);
                check("wr_data", mem_wdata, w.dat);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic start_reset();
        rst      = 1'b1;
        ex_ready = 1'b0;
        st_valid = 1'b0;
        st_data  = 8'h00;
        for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int a0;
        int w0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;

        // Reset state, then a LOAD with operand fetch
        start_reset();
        load(4'h0, 8'h4C);
        load(4'hC, 8'h0B);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_st_ready", st_ready, 0);
        check("rst_halted", halted, 0);
        check("rst_wdata", mem_wdata, 8'h00);
        check("rst_pc", pc, 4'h0);
        ex_q.push_back('{4'h4, 4'hC, 8'h0B});
        ex_ready = 1'b1;
        release_reset();
        check("ld_fetch_read", mem_read, 1);
        check("ld_fetch_addr", mem_address, 4'h0);
        step(1);
        check("ld_decode_idle", mem_read, 0);
        check("ld_pc_inc", pc, 4'h1);
        step(1);
        check("ld_operand_addr", mem_address, 4'hC);
        step(1);
        check("ld_ex_valid_c3", ex_valid, 1);
        step(1);
        check("ld_after_valid", ex_valid, 0);
        check("ld_next_fetch", mem_address, 4'h1);
        check("ld_next_read", mem_read, 1);
        ex_ready = 1'b0;

        // Back-pressure in ISSUE
        start_reset();
        load(4'h0, 8'h61);
        load(4'h1, 8'h33);
        ex_q.push_back('{4'h6, 4'h1, 8'h33});
        release_reset();
        step(3);
        a0 = accepts;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", ex_valid, 1);
            check("bp_opcode", ex_opcode, 4'h6);
            check("bp_addr", ex_addr, 4'h1);
            check("bp_operand", ex_operand, 8'h33);
            check("bp_no_access", mem_read | mem_write, 0);
            check("bp_pc", pc, 4'h1);
            step(1);
        end
        ex_ready = 1'b1;
        step(1);
        check("bp_one_accept", accepts, a0 + 1);
        check("bp_fetch_addr", mem_address, 4'h1);
        ex_ready = 1'b0;

        // STORE to A
        start_reset();
        load(4'h0, 8'h5A);
        ex_ready = 1'b1;
        st_valid = 1'b1;
        st_data  = 8'hFE;
        ex_q.push_back('{4'h5, 4'hA, 8'h00});
        wr_q.push_back('{4'hA, 8'hFE});
        w0 = writes;
        release_reset();
        step(2);
        check("st_ex_valid_c2", ex_valid, 1);
        step(1);
        check("st_ready", st_ready, 1);
        check("st_no_write_yet", mem_write, 0);
        step(1);
        check("st_write", mem_write, 1);
        check("st_write_noread", mem_read, 0);
        check("st_write_addr", mem_address, 4'hA);
        check("st_write_data", mem_wdata, 8'hFE);
        step(1);
        check("st_write_done", mem_write, 0);
        check("st_one_write", writes, w0 + 1);
        check("st_mem_a", mem[4'hA], 8'hFE);
        check("st_pc", pc, 4'h1);
        ex_ready = 1'b0;
        st_valid = 1'b0;

        // NOP at 15 wraps the PC
        start_reset();
        load(4'h0, 8'h8F);
        load(4'hF, 8'h77);
        release_reset();
        step(1);
        check("nop_pc1", pc, 4'h1);
        step(1);
        check("jmp_f_addr", mem_address, 4'hF);
        check("jmp_f_pc", pc, 4'hF);
        step(1);
        check("nop_wrap_pc", pc, 4'h0);
        step(1);
        check("nop_fetch0", mem_address, 4'h0);
        check("nop_no_valid", ex_valid, 0);

        // JMP 3
        start_reset();
        load(4'h0, 8'h83);
        release_reset();
        step(1);
        check("jmp_decode_noex", ex_valid, 0);
        step(1);
        check("jmp_fetch_addr", mem_address, 4'h3);
        check("jmp_fetch_read", mem_read, 1);
        check("jmp_pc", pc, 4'h3);

        // HALT
        start_reset();
        load(4'h0, 8'hE0);
        release_reset();
        step(1);
        check("halt_not_yet", halted, 0);
        step(1);
        check("halt_set", halted, 1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("halt_hold", halted, 1);
            check("halt_no_access", mem_read | mem_write, 0);
            check("halt_no_valid", ex_valid, 0);
        end

        // Reset during WRITE
        start_reset();
        load(4'h0, 8'h5A);
        load(4'hA, 8'h11);
        ex_ready = 1'b1;
        st_valid = 1'b1;
        st_data  = 8'h3C;
        ex_q.push_back('{4'h5, 4'hA, 8'h00});
        release_reset();
        step(4);
        check("rw_in_write", mem_write, 1);
        rst = 1'b1;
        #1;
        check("rw_write_dropped", mem_write, 0);
        check("rw_pc", pc, 4'h0);
        check("rw_read_quiet", mem_read, 0);
        check("rw_wdata", mem_wdata, 8'h00);
        step(1);
        check("rw_mem_unchanged", mem[4'hA], 8'h11);
        st_valid = 1'b0;
        ex_q.push_back('{4'h5, 4'hA, 8'h00});
        release_reset();
        check("rw_refetch_read", mem_read, 1);
        check("rw_refetch_addr", mem_address, 4'h0);
        step(2);
        check("rw_resume_valid", ex_valid, 1);
        step(3);
        check("rw_store_wait", st_ready, 1);
        check("rw_no_write", mem_write, 0);
        ex_ready = 1'b0;

        step(1);
        check("ex_queue_drained", ex_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Bus master placed directly upstream of the 16x8 instruction/data memory. Owns the PC and drives the memory's address/read/write/data_in.
- Fetches 8-bit instructions, formatted as opcode[7:4] and address[3:0]. Reads the operand from M[address] and hands opcode plus operand to the execute stage over a valid/ready handshake.
- Writes store data back to memory. Handles JMP, NOP and HALT locally.

Parameters:
- ADDR_W, 4: memory address width; PC width.
- DATA_W, 8: memory word width; opcode width = DATA_W-ADDR_W.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_address  out  ADDR_W  memory address.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable (level-sensitive at memory).
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data, combinationally valid while mem_read=1.
- ex_valid  out  1  instruction+operand offered to execute.
- ex_ready  in  1  execute accepts.
- ex_opcode  out  DATA_W-ADDR_W  opcode of offered instruction.
- ex_addr  out  ADDR_W  address field of offered instruction.
- ex_operand  out  DATA_W  M[ex_addr] for read-class ops; 0 for STORE.
- st_valid  in  1  execute presents store data (AC).
- st_data  in  DATA_W  value to store.
- st_ready  out  1  sequencer waiting for store data.
- pc  out  ADDR_W  current PC.
- halted  out  1  HALT executed.

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, IR=0, operand=0. All of mem_read, mem_write, ex_valid, st_ready and halted go to 0, and mem_wdata=0. Reset mid-write drops mem_write at once, with no partial-cycle write beyond the reset assertion.
- Glitch rule: mem_address, mem_read, mem_write and mem_wdata are decoded only from the state register and internal registers, never from inputs. Address and data are stable for the whole cycle mem_write=1.
- FETCH: mem_read=1, mem_address=pc. At the edge: IR<=mem_rdata, pc<=pc+1 (15 wraps to 0). Next state DECODE.
- DECODE: no memory access. Next state depends on IR[7:4]:
  - OP_HALT: go to HALTED.
  - OP_NOP: go to FETCH.
  - OP_JMP: pc<=IR[3:0], then FETCH.
  - OP_STORE: operand<=0, then ISSUE.
  - Any other opcode: go to OPERAND.
- OPERAND: mem_read=1, mem_address=IR[3:0]. At the edge operand<=mem_rdata, then ISSUE.
- ISSUE: ex_valid=1, with ex_opcode, ex_addr and ex_operand held stable. Leave only on ex_valid&&ex_ready: to STORE_WAIT if OP_STORE, otherwise to FETCH.
- STORE_WAIT: st_ready=1. On st_valid, wdata_reg<=st_data and go to WRITE.
- WRITE: mem_write=1, mem_address=IR[3:0], mem_wdata=wdata_reg for exactly one cycle, then FETCH. mem_read=0.
- HALTED: halted=1 and no memory access. Exit only by reset.
- mem_read and mem_write are never both 1.
- Latency from entry to FETCH:
  - Read-class ops: ex_valid at cycle 3.
  - STORE: ex_valid at cycle 2, write at earliest cycle 4.
  - NOP and JMP: 2 cycles per instruction.
- Self-modifying store to an address not yet fetched is visible to the later fetch.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants: OP_LOAD=4'h4, OP_STORE=4'h5, OP_TWOS=4'h6, OP_NOP=4'h7, OP_JMP=4'h8, OP_HALT=4'hE.
  - The state enum: FETCH, DECODE, OPERAND, ISSUE, STORE_WAIT, WRITE, HALTED.
  - ADDR_W and DATA_W defaults.
- No sub-module. The FSM, PC and IR fit in one module.

Test Plan:
- Reset release with M0=8'h4C, M12=8'h0B, ex_ready=1 -> ex_valid at cycle 3 with ex_opcode=4, ex_addr=C, ex_operand=8'h0B. Then pc=1 and the next fetch is at address 1.
- Hold ex_ready=0 for 5 cycles during ISSUE -> ex_* stable, no memory access, pc unchanged. Release -> exactly one accept.
- M0=8'h5A (STORE to A), ex_ready=1, st_valid=1 with st_data=8'hFE -> one mem_write cycle at address A with mem_wdata=FE, then M[A] reads FE. mem_read stays 0 during WRITE.
- M15=8'h77 (NOP) with pc=15 -> pc wraps to 0. M0=8'h83 (JMP 3) -> next fetch address 3, no ex_valid.
- Fetch of 8'hE0 -> halted=1 two cycles after fetch. mem_read/mem_write stay 0 indefinitely, and ex_valid stays 0.
- Assert rst during the WRITE cycle -> mem_write drops immediately, pc=0, state FETCH. Release -> the fetch of M0 resumes normally.
